// File: rtl/rotator_engine.sv
// rotator_engine: WIDTH-bit data register with a multi-step rotate/shift
// command engine. A start command latches mode/shamt/steps, and a three-state
// FSM (IDLE/RUN/DONE) applies one barrel operation per enabled cycle.
// Optional feature macro: ROTENG_PARITY_EN adds a registered parity output
// equal to ^data_out.
// Handshake: load/start are single-cycle strobes accepted only in IDLE with
// enable=1 (load wins over start); busy is high while steps are pending and
// done pulses for one cycle with the final data_out valid alongside it.
`timescale 1ns/1ps
module rotator_engine #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               load,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [CNT_W-1:0]   steps,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
`ifdef ROTENG_PARITY_EN
  ,
  output logic               parity
`endif
);

  localparam logic [2:0] MODE_ROL = 3'b000;
  localparam logic [2:0] MODE_ROR = 3'b001;
  localparam logic [2:0] MODE_SHL = 3'b010;
  localparam logic [2:0] MODE_SHR = 3'b011;
  localparam logic [2:0] MODE_SAR = 3'b100;
  localparam logic [31:0] WIDTH_U = WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [2:0]           mode_q;
  logic [2:0]           mode_nx;
  logic [SHAMT_W-1:0]   shamt_q;
  logic [SHAMT_W-1:0]   shamt_nx;
  logic [CNT_W-1:0]     rem_q;
  logic [CNT_W-1:0]     rem_nx;
  logic [WIDTH-1:0]     data_nx;
  logic [WIDTH-1:0]     step_val;

  // Barrel helpers: rotates use a doubled word so any amount below WIDTH
  // wraps naturally; shift amounts of WIDTH or more saturate to pure fill.
  logic [31:0]              rot_amt;
  logic [2*WIDTH-1:0]       rol_dbl;
  logic [2*WIDTH-1:0]       ror_dbl;
  logic                     shift_ovf;
  logic signed [WIDTH-1:0]  sar_val;

  assign rot_amt   = 32'(shamt_q) % WIDTH_U;
  assign rol_dbl   = {data_out, data_out} << rot_amt;
  assign ror_dbl   = {data_out, data_out} >> rot_amt;
  assign shift_ovf = (32'(shamt_q) >= WIDTH_U);
  assign sar_val   = $signed(data_out) >>> shamt_q;

  // One step of the latched operation applied to the current register value.
  always_comb begin
    step_val = data_out;
    case (mode_q)
      MODE_ROL: step_val = rol_dbl[2*WIDTH-1:WIDTH];
      MODE_ROR: step_val = ror_dbl[WIDTH-1:0];
      MODE_SHL: step_val = shift_ovf ? '0 : (data_out << shamt_q);
      MODE_SHR: step_val = shift_ovf ? '0 : (data_out >> shamt_q);
      MODE_SAR: step_val = shift_ovf ? {WIDTH{data_out[WIDTH-1]}} : sar_val;
      default:  step_val = data_out;
    endcase
  end

  // Next-state, next-data and command latching for the IDLE/RUN/DONE FSM.
  always_comb begin
    state_nx = state;
    data_nx  = data_out;
    rem_nx   = rem_q;
    mode_nx  = mode_q;
    shamt_nx = shamt_q;
    case (state)
      IDLE: begin
        if (enable) begin
          if (load) begin
            data_nx = data_in;
          end else if (start) begin
            mode_nx  = mode;
            shamt_nx = shamt;
            rem_nx   = steps;
            state_nx = (steps == '0) ? DONE : RUN;
          end
        end
      end
      RUN: begin
        if (enable) begin
          data_nx = step_val;
          rem_nx  = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, datapath and status registers; reset abandons any command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_out <= '0;
      rem_q    <= '0;
      mode_q   <= '0;
      shamt_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      data_out <= data_nx;
      rem_q    <= rem_nx;
      mode_q   <= mode_nx;
      shamt_q  <= shamt_nx;
      busy     <= (state_nx == RUN);
      done     <= (state_nx == DONE);
    end
  end

`ifdef ROTENG_PARITY_EN
  // Parity tracks the value being written so it always equals ^data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity <= 1'b0;
    else        parity <= ^data_nx;
  end
`endif

endmodule

// File: tb/tb_rotator_engine.sv
// Bench for rotator_engine: an 8-bit instance driven from a vector table,
// random vectors checked against a bitwise reference, hand sequences for
// pause / ignored strobes / load-vs-start, and a 16-bit instance for the
// wide rotate and mid-command reset cases.
`timescale 1ns/1ps
module tb_rotator_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- 8-bit instance ----------------
  logic       en8, load8, start8;
  logic [7:0] din8, dout8, steps8;
  logic [2:0] mode8, sh8;
  logic       busy8, done8;
`ifdef ROTENG_PARITY_EN
  logic       parity8;
`endif

  rotator_engine #(.WIDTH(8), .SHAMT_W(3), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable(en8), .load(load8), .data_in(din8),
    .start(start8), .mode(mode8), .shamt(sh8), .steps(steps8),
    .data_out(dout8), .busy(busy8), .done(done8)
`ifdef ROTENG_PARITY_EN
    , .parity(parity8)
`endif
  );

  // ---------------- 16-bit instance ----------------
  logic        en16, load16, start16;
  logic [15:0] din16, dout16;
  logic [7:0]  steps16;
  logic [2:0]  mode16;
  logic [3:0]  sh16;
  logic        busy16, done16;
`ifdef ROTENG_PARITY_EN
  logic        parity16;
`endif

  rotator_engine #(.WIDTH(16), .SHAMT_W(4), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .enable(en16), .load(load16), .data_in(din16),
    .start(start16), .mode(mode16), .shamt(sh16), .steps(steps16),
    .data_out(dout16), .busy(busy16), .done(done16)
`ifdef ROTENG_PARITY_EN
    , .parity(parity16)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [15:0] exp16_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bitwise reference: moves each bit individually, n steps of shift s.
  function automatic logic [7:0] ref8(input logic [7:0] d, input logic [2:0] m,
                                      input int s, input int n);
    logic [7:0] r;
    for (int k = 0; k < n; k++) begin
      r = '0;
      for (int i = 0; i < 8; i++) begin
        case (m)
          3'd0:    r[(i + s) % 8] = d[i];
          3'd1:    r[i] = d[(i + s) % 8];
          3'd2:    r[i] = (i >= s) ? d[i - s] : 1'b0;
          3'd3:    r[i] = (i + s < 8) ? d[i + s] : 1'b0;
          3'd4:    r[i] = (i + s < 8) ? d[i + s] : d[7];
          default: r[i] = d[i];
        endcase
      end
      d = r;
    end
    return d;
  endfunction

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_load8(input logic [7:0] v);
    en8 = 1'b1; load8 = 1'b1; din8 = v;
    @(posedge clk); #1;
    load8 = 1'b0;
  endtask

  task automatic cmd8(input logic [2:0] m, input logic [2:0] s, input logic [7:0] n);
    mode8 = m; sh8 = s; steps8 = n; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Waits for done, counting busy cycles, then compares against the queue.
  task automatic wait_done8(input int exp_busy, input string name);
    int busy_cnt;
    bit seen;
    logic [7:0] exp;
    busy_cnt = 0;
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      if (done8) begin
        seen = 1;
        break;
      end
      if (busy8) busy_cnt++;
      @(posedge clk); #1;
    end
    exp = exp_q.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout no done pulse within budget", name);
    end else begin
      chk({name, "_data"}, 32'(dout8), 32'(exp));
      chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
      chk({name, "_busy_at_done"}, 32'(busy8), 0);
`ifdef ROTENG_PARITY_EN
      chk({name, "_parity"}, 32'(parity8), 32'(^dout8));
`endif
      @(posedge clk); #1;
      chk({name, "_done_one_cycle"}, 32'(done8), 0);
      chk({name, "_idle_busy"}, 32'(busy8), 0);
    end
  endtask

  typedef struct {
    logic [7:0] init;
    logic [2:0] mode;
    logic [2:0] sh;
    logic [7:0] steps;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int seen_done;
    int seen_busy;
    logic [7:0] rd, rs;
    logic [2:0] rm, rsh;

    // vector table: {init, mode, shamt, steps, expected data_out}
    vecs[0] = '{8'h12, 3'd0, 3'd3, 8'd2, 8'h84};
    vecs[1] = '{8'h84, 3'd1, 3'd1, 8'd4, 8'h48};
    vecs[2] = '{8'h80, 3'd4, 3'd2, 8'd3, 8'hFE};
    vecs[3] = '{8'h80, 3'd3, 3'd2, 8'd3, 8'h02};
    vecs[4] = '{8'h81, 3'd2, 3'd7, 8'd2, 8'h00};
    vecs[5] = '{8'h3C, 3'd5, 3'd1, 8'd3, 8'h3C};
    vecs[6] = '{8'hA5, 3'd0, 3'd0, 8'd2, 8'hA5};
    vecs[7] = '{8'h5B, 3'd1, 3'd3, 8'd0, 8'h5B};
    vecs[8] = '{8'hC3, 3'd4, 3'd7, 8'd1, 8'hFF};
    vecs[9] = '{8'h96, 3'd3, 3'd7, 8'd1, 8'h01};

    rst_n = 1'b0;
    en8 = 0; load8 = 0; start8 = 0; din8 = 0; mode8 = 0; sh8 = 0; steps8 = 0;
    en16 = 0; load16 = 0; start16 = 0; din16 = 0; mode16 = 0; sh16 = 0; steps16 = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_data", 32'(dout8), 0);
    chk("reset_busy", 32'(busy8), 0);
    chk("reset_done", 32'(done8), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // enable=0: load and start ignored
    en8 = 0; load8 = 1; din8 = 8'h5A;
    @(posedge clk); #1;
    load8 = 0;
    chk("disabled_load", 32'(dout8), 0);
    start8 = 1; steps8 = 8'd1;
    @(posedge clk); #1;
    start8 = 0;
    chk("disabled_start_busy", 32'(busy8), 0);

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      do_load8(vecs[i].init);
      exp_q.push_back(vecs[i].exp);
      cmd8(vecs[i].mode, vecs[i].sh, vecs[i].steps);
      wait_done8(int'(vecs[i].steps), $sformatf("vec%0d", i));
    end

    // random vectors against the bitwise reference
    for (int i = 0; i < 8; i++) begin
      rd  = 8'($urandom_range(0, 255));
      rm  = 3'($urandom_range(0, 7));
      rsh = 3'($urandom_range(0, 7));
      rs  = 8'($urandom_range(0, 5));
      do_load8(rd);
      exp_q.push_back(ref8(rd, rm, int'(rsh), int'(rs)));
      cmd8(rm, rsh, rs);
      wait_done8(int'(rs), $sformatf("rand%0d", i));
    end

    // pause: ROR 1 x4 from 0x84, enable low for 3 cycles after step 2
    do_load8(8'h84);
    exp_q.push_back(8'h48);
    cmd8(3'd1, 3'd1, 8'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pause_after2", 32'(dout8), 32'h21);
    en8 = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("pause_hold_data%0d", c), 32'(dout8), 32'h21);
      chk($sformatf("pause_hold_busy%0d", c), 32'(busy8), 1);
      chk($sformatf("pause_hold_done%0d", c), 32'(done8), 0);
    end
    en8 = 1;
    wait_done8(2, "pause");

    // start pulsed during RUN is ignored
    do_load8(8'h01);
    exp_q.push_back(8'h10);
    cmd8(3'd0, 3'd1, 8'd4);
    mode8 = 3'd2; sh8 = 3'd3; steps8 = 8'd1; start8 = 1;
    @(posedge clk); #1;
    start8 = 0;
    wait_done8(3, "start_in_run");
    @(posedge clk); #1;
    chk("start_in_run_no_requeue", 32'(busy8), 0);

    // load and start together: load wins
    en8 = 1; load8 = 1; start8 = 1; din8 = 8'h77; mode8 = 3'd0; sh8 = 3'd1; steps8 = 8'd2;
    @(posedge clk); #1;
    load8 = 0; start8 = 0;
    chk("load_start_data", 32'(dout8), 32'h77);
    chk("load_start_busy", 32'(busy8), 0);
    @(posedge clk); #1;
    chk("load_start_busy2", 32'(busy8), 0);
    chk("load_start_done2", 32'(done8), 0);
    chk("load_start_hold", 32'(dout8), 32'h77);

    // 16-bit instance: ROL 15 x1 from 0x0001
    en16 = 1; load16 = 1; din16 = 16'h0001;
    @(posedge clk); #1;
    load16 = 0;
    exp16_q.push_back(16'h8000);
    mode16 = 3'd0; sh16 = 4'd15; steps16 = 8'd1; start16 = 1;
    @(posedge clk); #1;
    start16 = 0;
    seen_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (done16) begin
        seen_done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("w16_done_seen", seen_done, 1);
    chk("w16_rol15", 32'(dout16), 32'(exp16_q.pop_front()));
    @(posedge clk); #1;

    // ROL 1 x100, reset at the 50th step
    mode16 = 3'd0; sh16 = 4'd1; steps16 = 8'd100; start16 = 1;
    @(posedge clk); #1;
    start16 = 0;
    repeat (49) begin
      @(posedge clk); #1;
    end
    chk("w16_after49", 32'(dout16), 32'h0001);
    chk("w16_busy_mid", 32'(busy16), 1);
    rst_n = 1'b0;
    #1;
    chk("w16_reset_data", 32'(dout16), 0);
    chk("w16_reset_busy", 32'(busy16), 0);
    chk("w16_reset_done", 32'(done16), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 0;
    seen_busy = 0;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1;
      if (done16) seen_done++;
      if (busy16) seen_busy++;
    end
    chk("w16_no_done_after_reset", seen_done, 0);
    chk("w16_no_busy_after_reset", seen_busy, 0);
    chk("w16_data_after_reset", 32'(dout16), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
